axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
Shares the single AXI4 read channel (AR + R) between the instruction-cache refill path (requester I) and the data-cache refill path (requester D). It grants one requester at a time, holds the grant from AR issue until the last R beat, and routes the handshakes. It sits between both caches and the top-level m_axi read ports, and replaces the ad-hoc data_cache_reading/instruction_cache_reading interlock with a single owner of the bus.

Parameters:
addr_width, 64, AXI address width
data_width, 64, AXI read data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
i_arvalid / d_arvalid  in  1  requester read-address valid
i_araddr / d_araddr  in  addr_width  requester address
i_arlen / d_arlen  in  8  burst length minus 1
i_arsize / d_arsize  in  3  beat size
i_arburst / d_arburst  in  2  burst type
i_arready / d_arready  out  1  AR accepted by memory for this requester
i_rvalid / d_rvalid  out  1  R beat valid to this requester
i_rdata / d_rdata  out  data_width  R data
i_rlast / d_rlast  out  1  last beat
i_rready / d_rready  in  1  requester accepts beat
m_axi_arvalid, m_axi_araddr[addr_width], m_axi_arlen[8], m_axi_arsize[3], m_axi_arburst[2]  out  AXI AR channel
m_axi_arready  in  1
m_axi_rvalid, m_axi_rlast  in  1;  m_axi_rdata  in  data_width
m_axi_rready  out  1
icache_active  out  1  I holds the grant (ADDR or DATA)
dcache_active  out  1  D holds the grant
len_error  out  1  sticky: beat count did not match arlen at rlast

Behaviour:
- Clock is clock; reset is synchronous, active-high. On reset: state=IDLE, grant=none, last_grant=I (so D wins the first tie), beat_cnt=0, latched_len=0, len_error=0. All outputs are 0 while reset is high and in IDLE.
- States: IDLE, ADDR, DATA.
- IDLE: no m_axi outputs asserted. Arbitrate on i_arvalid/d_arvalid:
  - only one valid -> grant it;
  - both valid -> grant the one not equal to last_grant (round-robin).
  - Grant is registered. Next cycle: state=ADDR, last_grant updated.
- ADDR: m_axi_ar* driven combinationally from the granted requester. m_axi_arvalid = granted arvalid. Granted x_arready = m_axi_arready. Non-granted arready = 0.
  - On m_axi_arvalid && m_axi_arready: latch arlen into latched_len, beat_cnt=0, next state=DATA.
  - If granted arvalid drops before the handshake: return to IDLE next cycle, grant released. This is a legal abort, e.g. on a jump flush.
- DATA: m_axi_rdata/rlast/rvalid routed to the granted requester only. m_axi_rready = granted x_rready. Non-granted rvalid = 0.
  - Each beat handshake (m_axi_rvalid && m_axi_rready) increments beat_cnt. beat_cnt is 8 bits and wraps; wrap is only reachable on a protocol error.
  - On the handshake with m_axi_rlast=1: if beat_cnt != latched_len, set len_error (sticky until reset). Then next state=IDLE, grant cleared.
  - m_axi_rvalid without a handshake: hold, no count.
- The new arbitration takes effect in IDLE, so there is exactly one bubble cycle between one burst's rlast and the next m_axi_arvalid.
- A new request arriving during ADDR/DATA waits; the requester holds arvalid. No pre-emption once the grant is given.
- icache_active = grant==I && state!=IDLE; dcache_active likewise. The two are never both 1.
- m_axi_rdata is passed to both requesters, since data is don't-care without rvalid; the rvalid gating is mandatory.
- Reset mid-burst: the arbiter returns to IDLE immediately. The memory side is reset by the same signal.
- Latency: arvalid rising in IDLE at cycle N -> m_axi_arvalid high at N+1.

Test Plan:
- Single I request, araddr=0x1000, arlen=7, arready at first cycle, 8 beats with rlast on beat 8 -> m_axi_araddr=0x1000 at N+1, i_rvalid pulses 8 times, icache_active 1 until rlast, len_error=0.
- I and D assert arvalid together from reset -> D granted first (burst completes), one bubble cycle, then I granted; repeat simultaneously -> alternates D, I, D.
- D in DATA, I asserts arvalid mid-burst -> i_arready=0 and i_rvalid=0 throughout the D burst; I granted after D rlast + 1 cycle.
- Granted I drops arvalid in ADDR with m_axi_arready=0 -> IDLE next cycle, icache_active=0, no m_axi_arvalid the following cycle.
- arlen=7 but rlast on beat 6 -> len_error=1 and stays 1 through later good bursts until reset.
- Reset asserted during beat 4 of a D burst -> next cycle all outputs 0, state IDLE; a fresh I request is then served normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin owner of the shared AXI4 read channel between the I-cache and D-cache refill paths.
// The grant is held from AR issue through the last R beat; the other requester is fully masked.
module axi_read_arbiter #(
  parameter int addr_width = 64,
  parameter int data_width = 64
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  i_arvalid,
  input  logic [addr_width-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  output logic                  i_arready,
  output logic                  i_rvalid,
  output logic [data_width-1:0] i_rdata,
  output logic                  i_rlast,
  input  logic                  i_rready,

  input  logic                  d_arvalid,
  input  logic [addr_width-1:0] d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic [2:0]            d_arsize,
  input  logic [1:0]            d_arburst,
  output logic                  d_arready,
  output logic                  d_rvalid,
  output logic [data_width-1:0] d_rdata,
  output logic                  d_rlast,
  input  logic                  d_rready,

  output logic                  m_axi_arvalid,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  input  logic [data_width-1:0] m_axi_rdata,
  output logic                  m_axi_rready,

  output logic                  icache_active,
  output logic                  dcache_active,
  output logic                  len_error
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

  state_t     r_state;
  grant_t     r_grant;
  grant_t     r_last_grant;
  logic [7:0] r_beat_cnt;
  logic [7:0] r_latched_len;
  logic       r_len_error;

  logic   w_run;
  logic   w_sel_i;
  logic   w_sel_d;
  logic   w_in_addr;
  logic   w_in_data;
  logic   w_arvalid_g;
  logic   w_rready_g;
  logic   w_ar_hs;
  logic   w_r_hs;
  grant_t w_pick;

  // Outputs are forced low while reset is held, even if the state register is still mid-burst.
  assign w_run     = !reset;
  assign w_sel_i   = (r_grant == G_I);
  assign w_sel_d   = (r_grant == G_D);
  assign w_in_addr = w_run && (r_state == S_ADDR);
  assign w_in_data = w_run && (r_state == S_DATA);

  assign w_arvalid_g = (w_sel_i && i_arvalid) || (w_sel_d && d_arvalid);
  assign w_rready_g  = (w_sel_i && i_rready)  || (w_sel_d && d_rready);
  assign w_ar_hs     = m_axi_arvalid && m_axi_arready;
  assign w_r_hs      = m_axi_rvalid && m_axi_rready;

  // Tie goes to whoever did not win last time.
  always_comb begin
    w_pick = G_NONE;
    if (i_arvalid && d_arvalid)
      w_pick = (r_last_grant == G_I) ? G_D : G_I;
    else if (i_arvalid)
      w_pick = G_I;
    else if (d_arvalid)
      w_pick = G_D;
  end

  always_comb begin
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    if (w_in_addr && w_sel_i) begin
      m_axi_araddr  = i_araddr;
      m_axi_arlen   = i_arlen;
      m_axi_arsize  = i_arsize;
      m_axi_arburst = i_arburst;
    end else if (w_in_addr && w_sel_d) begin
      m_axi_araddr  = d_araddr;
      m_axi_arlen   = d_arlen;
      m_axi_arsize  = d_arsize;
      m_axi_arburst = d_arburst;
    end
  end

  assign m_axi_arvalid = w_in_addr && w_arvalid_g;
  assign i_arready     = w_in_addr && w_sel_i && m_axi_arready;
  assign d_arready     = w_in_addr && w_sel_d && m_axi_arready;

  assign m_axi_rready  = w_in_data && w_rready_g;
  assign i_rvalid      = w_in_data && w_sel_i && m_axi_rvalid;
  assign d_rvalid      = w_in_data && w_sel_d && m_axi_rvalid;
  assign i_rlast       = w_in_data && w_sel_i && m_axi_rlast;
  assign d_rlast       = w_in_data && w_sel_d && m_axi_rlast;
  // Data fans out to both sides; only rvalid qualifies it.
  assign i_rdata       = w_in_data ? m_axi_rdata : '0;
  assign d_rdata       = w_in_data ? m_axi_rdata : '0;

  assign icache_active = w_run && w_sel_i && (r_state != S_IDLE);
  assign dcache_active = w_run && w_sel_d && (r_state != S_IDLE);
  assign len_error     = w_run && r_len_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= G_NONE;
      r_last_grant  <= G_I;
      r_beat_cnt    <= '0;
      r_latched_len <= '0;
      r_len_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick != G_NONE) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_ar_hs) begin
            r_latched_len <= m_axi_arlen;
            r_beat_cnt    <= '0;
            r_state       <= S_DATA;
          end else if (!w_arvalid_g) begin
            r_grant <= G_NONE;
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (m_axi_rlast) begin
              // Count before this beat equals arlen exactly when the burst had arlen+1 beats.
              if (r_beat_cnt != r_latched_len)
                r_len_error <= 1'b1;
              r_grant <= G_NONE;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_grant <= G_NONE;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
